// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan reader: segment bit positions, the
// hex glyph table, FSM states and the capture record passed to the output stage.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Glyphs as emitted by the team's segment decoders, bit order gfedcba
    localparam logic [SEG_W-1:0] PAT_0 = 7'h3F;
    localparam logic [SEG_W-1:0] PAT_1 = 7'h06;
    localparam logic [SEG_W-1:0] PAT_2 = 7'h5B;
    localparam logic [SEG_W-1:0] PAT_3 = 7'h4F;
    localparam logic [SEG_W-1:0] PAT_4 = 7'h66;
    localparam logic [SEG_W-1:0] PAT_5 = 7'h6D;
    localparam logic [SEG_W-1:0] PAT_6 = 7'h7D;
    localparam logic [SEG_W-1:0] PAT_7 = 7'h07;
    localparam logic [SEG_W-1:0] PAT_8 = 7'h7F;
    localparam logic [SEG_W-1:0] PAT_9 = 7'h6F;
    localparam logic [SEG_W-1:0] PAT_A = 7'h77;
    localparam logic [SEG_W-1:0] PAT_B = 7'h7C;
    localparam logic [SEG_W-1:0] PAT_C = 7'h39;
    localparam logic [SEG_W-1:0] PAT_D = 7'h5E;
    localparam logic [SEG_W-1:0] PAT_E = 7'h79;
    localparam logic [SEG_W-1:0] PAT_F = 7'h71;

    // Wide enough for any practical digit count; the top narrows it at its port
    localparam int DIGIT_W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    typedef struct packed {
        logic [DIGIT_W_MAX-1:0] digit;
        logic [3:0]             value;
        logic                   err;
    } cap_rec_t;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Valid/ready record channel carrying one decoded digit capture per transfer.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int DW = $clog2(NUM_DIGITS);

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_digit;
    logic [3:0]    out_value;
    logic          out_err;

    modport master (
        output out_valid,
        output out_digit,
        output out_value,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_value,
        input  out_err,
        output out_ready
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Maps a 7-segment glyph back to its hex value; anything outside the table
// reports err with value 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       value,
    output logic             err
);

    always_comb begin
        value = 4'h0;
        err   = 1'b0;
        case (pattern)
            PAT_0:   value = 4'h0;
            PAT_1:   value = 4'h1;
            PAT_2:   value = 4'h2;
            PAT_3:   value = 4'h3;
            PAT_4:   value = 4'h4;
            PAT_5:   value = 4'h5;
            PAT_6:   value = 4'h6;
            PAT_7:   value = 4'h7;
            PAT_8:   value = 4'h8;
            PAT_9:   value = 4'h9;
            PAT_A:   value = 4'hA;
            PAT_B:   value = 4'hB;
            PAT_C:   value = 4'hC;
            PAT_D:   value = 4'hD;
            PAT_E:   value = 4'hE;
            PAT_F:   value = 4'hF;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Loopback monitor for the multiplexed 7-segment bus: waits for each digit's
// glyph to settle, decodes it once, and offers it on a single-entry output.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEG_W-1:0]      seg_in,
    input  logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  drop_pulse,
    seg7_scan_reader_if.master    out
);

    localparam int DW    = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    logic [SEG_W-1:0]      s_seg;
    logic [SEG_W-1:0]      p_seg;
    logic [NUM_DIGITS-1:0] s_sel;
    logic [NUM_DIGITS-1:0] p_sel;

    logic                  same;
    logic                  onehot;
    logic [DW-1:0]         sel_idx;
    logic [3:0]            dec_value;
    logic                  dec_err;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  cap_valid;
    cap_rec_t              cap_rec;

    logic                  out_valid_q;
    cap_rec_t              out_rec;

    // Polarity is normalised here so everything downstream sees active-high lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_sel <= '0;
            p_seg <= '0;
            p_sel <= '0;
        end else begin
            s_seg <= SEG_ACTIVE_LOW ? ~seg_in  : seg_in;
            s_sel <= SEG_ACTIVE_LOW ? ~dig_sel : dig_sel;
            p_seg <= s_seg;
            p_sel <= s_sel;
        end
    end

    assign same   = (s_seg == p_seg) && (s_sel == p_sel);
    assign onehot = (s_sel != '0) && ((s_sel & (s_sel - NUM_DIGITS'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s_sel[i]) sel_idx = DW'(i);
        end
    end

    seg7_pattern_decode u_decode (
        .pattern (s_seg),
        .value   (dec_value),
        .err     (dec_err)
    );

    // HOLD remembers that the current glyph was already captured, so it is never re-emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_valid <= 1'b0;
            cap_rec   <= '0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (onehot) begin
                        state <= TRACK;
                        cnt   <= '0;
                    end
                end
                TRACK: begin
                    if (!onehot) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!same) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        cap_valid <= 1'b1;
                        cap_rec   <= '{digit: DIGIT_W_MAX'(sel_idx),
                                       value: dec_value,
                                       err:   dec_err};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!onehot) begin
                        state <= IDLE;
                    end else if (!same) begin
                        state <= TRACK;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A capture arriving while the held record is unaccepted is dropped, not queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_rec     <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (cap_valid) begin
                if (!out_valid_q || out.out_ready) begin
                    out_rec     <= cap_rec;
                    out_valid_q <= 1'b1;
                end else begin
                    drop_pulse <= 1'b1;
                end
            end else if (out_valid_q && out.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out.out_valid = out_valid_q;
    assign out.out_digit = out_rec.digit[DW-1:0];
    assign out.out_value = out_rec.value;
    assign out.out_err   = out_rec.err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scenario and randomized bench for seg7_scan_reader, checked against a
// run-length model of the display bus kept alongside the DUT.
module tb_seg7_scan_reader;
    import seg7_pkg::*;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in;
    logic [3:0] dig_sel;
    logic       drop_pulse;

    seg7_scan_reader_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_reader #(
        .NUM_DIGITS     (NUM_DIGITS),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .drop_pulse (drop_pulse),
        .out        (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        bit v;
        int digit;
        int value;
        bit err;
    } mrec_t;

    // Model: a glyph is captured when it has been seen on one digit for exactly
    // STABLE_CYCLES consecutive samples; the record appears two edges later.
    logic [6:0] prev_seg;
    logic [3:0] prev_sel;
    int         run_len;
    mrec_t      pend_fsm;
    mrec_t      pend_out;
    mrec_t      m_rec;
    bit         m_valid;
    bit         m_drop;

    function automatic int table_index(logic [6:0] pat);
        for (int i = 0; i < 16; i++) if (hex_table[i] == pat) return i;
        return -1;
    endfunction

    function automatic int digit_of(logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        prev_seg = '0;
        prev_sel = '0;
        run_len  = 0;
        pend_fsm = '{v: 0, digit: 0, value: 0, err: 0};
        pend_out = pend_fsm;
        m_rec    = pend_fsm;
        m_valid  = 0;
        m_drop   = 0;
    endtask

    task automatic model_edge();
        mrec_t evt;
        bit    oh;
        int    idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        evt        = pend_out;
        pend_out   = pend_fsm;
        pend_fsm.v = 0;
        oh = ($countones(dig_sel) == 1);
        if (oh && seg_in == prev_seg && dig_sel == prev_sel) run_len++;
        else run_len = oh ? 1 : 0;
        if (run_len == STABLE_CYCLES) begin
            idx = table_index(seg_in);
            pend_fsm = '{v: 1, digit: digit_of(dig_sel),
                         value: (idx < 0) ? 0 : idx, err: (idx < 0)};
        end
        prev_seg = seg_in;
        prev_sel = dig_sel;
        m_drop = 0;
        if (evt.v) begin
            if (!m_valid || bus.out_ready) begin
                m_valid = 1;
                m_rec   = evt;
            end else begin
                m_drop = 1;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] sel, input logic rdy);
        seg_in        = seg;
        dig_sel       = sel;
        bus.out_ready = rdy;
    endtask

    task automatic test_reset();
        drive(7'h00, 4'b0000, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.out_digit !== 2'd0) begin errors++; $display("[TB] FAIL reset_digit: got %0d expected 0", bus.out_digit); end
        checks++; if (bus.out_value !== 4'h0) begin errors++; $display("[TB] FAIL reset_value: got %0h expected 0", bus.out_value); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", bus.out_err); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop: got %0b expected 0", drop_pulse); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected IDLE", dut.state); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single_capture();
        int rise_at = -1, pulses = 0, drops = 0, dg = 0, vl = 0, er = 0;
        drive(7'h00, 4'b0000, 1'b1);
        repeat (3) tick();
        drive(7'h5B, 4'b0010, 1'b1);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (drop_pulse) drops++;
            if (bus.out_valid) begin
                pulses++;
                if (rise_at < 0) begin
                    rise_at = t; dg = bus.out_digit; vl = bus.out_value; er = bus.out_err;
                end
            end
        end
        checks++; if (rise_at != STABLE_CYCLES + 1) begin errors++; $display("[TB] FAIL single_latency: got %0d expected %0d", rise_at, STABLE_CYCLES + 1); end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", pulses); end
        checks++; if (dg != 1 || vl != 2 || er != 0) begin errors++; $display("[TB] FAIL single_record: got {%0d,%0h,%0d} expected {1,2,0}", dg, vl, er); end
        checks++; if (drops != 0) begin errors++; $display("[TB] FAIL single_drop: got %0d expected 0", drops); end
    endtask

    task automatic test_short_window();
        int pulses = 0, dg = -1, vl = -1, er = -1;
        drive(7'h00, 4'b0000, 1'b1);
        repeat (3) tick();
        for (int t = 0; t < 12; t++) begin
            if (t < 2) drive(7'h6D, 4'b0001, 1'b1);
            else       drive(7'h7D, 4'b0001, 1'b1);
            tick();
            if (bus.out_valid) begin
                pulses++; dg = bus.out_digit; vl = bus.out_value; er = bus.out_err;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL short_count: got %0d expected 1", pulses); end
        checks++; if (dg != 0 || vl != 6 || er != 0) begin errors++; $display("[TB] FAIL short_record: got {%0d,%0h,%0d} expected {0,6,0}", dg, vl, er); end
    endtask

    task automatic test_error_pattern();
        int pulses = 0, dg = -1, vl = -1, er = -1;
        drive(7'h00, 4'b0000, 1'b1);
        repeat (3) tick();
        drive(7'h49, 4'b1000, 1'b1);
        for (int t = 0; t < 8; t++) begin
            tick();
            if (bus.out_valid) begin
                pulses++; dg = bus.out_digit; vl = bus.out_value; er = bus.out_err;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL err_count: got %0d expected 1", pulses); end
        checks++; if (dg != 3 || vl != 0 || er != 1) begin errors++; $display("[TB] FAIL err_record: got {%0d,%0h,%0d} expected {3,0,1}", dg, vl, er); end
    endtask

    task automatic test_backpressure();
        int drops = 0, changed = 0;
        drive(7'h00, 4'b0000, 1'b0);
        repeat (3) tick();
        drive(7'h4F, 4'b0001, 1'b0);
        repeat (8) tick();
        drive(7'h77, 4'b0100, 1'b0);
        for (int t = 0; t < 8; t++) begin
            tick();
            if (drop_pulse) drops++;
            if (bus.out_valid && (bus.out_digit !== 2'd0 || bus.out_value !== 4'h3)) changed++;
        end
        checks++; if (drops != 1) begin errors++; $display("[TB] FAIL bp_drop_count: got %0d expected 1", drops); end
        checks++; if (changed != 0) begin errors++; $display("[TB] FAIL bp_record_stable: got %0d changes expected 0", changed); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 2'd0 || bus.out_value !== 4'h3 || bus.out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_held: got {%0b,%0d,%0h,%0b} expected {1,0,3,0}", bus.out_valid, bus.out_digit, bus.out_value, bus.out_err);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_accept: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_blanking();
        int valids = 0, not_idle = 0, pulses = 0, dg = -1, vl = -1, er = -1;
        drive(7'h3F, 4'b0110, 1'b1);
        for (int t = 0; t < 40; t++) begin
            if (t == 20) dig_sel = 4'b0000;
            tick();
            if (bus.out_valid) valids++;
            if (t > 2 && dut.state !== IDLE) not_idle++;
        end
        checks++; if (valids != 0) begin errors++; $display("[TB] FAIL blank_valid: got %0d expected 0", valids); end
        checks++; if (not_idle != 0) begin errors++; $display("[TB] FAIL blank_idle: got %0d non-IDLE cycles expected 0", not_idle); end
        dig_sel = 4'b0100;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (bus.out_valid) begin
                pulses++; dg = bus.out_digit; vl = bus.out_value; er = bus.out_err;
            end
        end
        checks++; if (pulses != 1 || dg != 2 || vl != 0 || er != 0) begin
            errors++; $display("[TB] FAIL blank_resume: got %0d records {%0d,%0h,%0d} expected 1 {2,0,0}", pulses, dg, vl, er);
        end
    endtask

    task automatic test_async_reset();
        int rise_at = -1, pulses = 0, dg = -1, vl = -1, er = -1;
        drive(7'h00, 4'b0000, 1'b1);
        repeat (3) tick();
        drive(7'h66, 4'b0001, 1'b0);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (dut.state !== IDLE || bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_track: got state %0d valid %0b expected IDLE 0", dut.state, bus.out_valid);
        end
        #2 rst_n = 1'b1;
        repeat (8) tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_refill: got %0b expected 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_digit !== 2'd0 || bus.out_value !== 4'h0 || bus.out_err !== 1'b0 || drop_pulse !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_pending: got {%0b,%0d,%0h,%0b,%0b} expected all 0", bus.out_valid, bus.out_digit, bus.out_value, bus.out_err, drop_pulse);
        end
        #2 rst_n = 1'b1;
        drive(7'h06, 4'b0100, 1'b1);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.out_valid) begin
                pulses++;
                if (rise_at < 0) begin
                    rise_at = t; dg = bus.out_digit; vl = bus.out_value; er = bus.out_err;
                end
            end
        end
        checks++; if (rise_at != STABLE_CYCLES + 1) begin errors++; $display("[TB] FAIL rst_latency: got %0d expected %0d", rise_at, STABLE_CYCLES + 1); end
        checks++; if (pulses != 1 || dg != 2 || vl != 1 || er != 0) begin
            errors++; $display("[TB] FAIL rst_record: got %0d records {%0d,%0h,%0d} expected 1 {2,1,0}", pulses, dg, vl, er);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int r;
        for (int t = 0; t < 600; t++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 8);
                r = $urandom_range(0, 99);
                if (r < 75)      dig_sel = 4'(1 << $urandom_range(0, 3));
                else if (r < 85) dig_sel = 4'b0000;
                else             dig_sel = 4'(3 << $urandom_range(0, 2));
                if ($urandom_range(0, 99) < 80) seg_in = hex_table[$urandom_range(0, 15)];
                else                            seg_in = 7'($urandom);
            end
            hold--;
            bus.out_ready = ($urandom_range(0, 99) < 60);
            tick();
            checks++; if (bus.out_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid @%0d: got %0b expected %0b", t, bus.out_valid, m_valid); end
            checks++; if (drop_pulse !== m_drop) begin errors++; $display("[TB] FAIL rand_drop @%0d: got %0b expected %0b", t, drop_pulse, m_drop); end
            if (m_valid) begin
                checks++;
                if (bus.out_digit !== 2'(m_rec.digit) || bus.out_value !== 4'(m_rec.value) || bus.out_err !== m_rec.err) begin
                    errors++; $display("[TB] FAIL rand_record @%0d: got {%0d,%0h,%0b} expected {%0d,%0h,%0b}", t,
                                       bus.out_digit, bus.out_value, bus.out_err, m_rec.digit, m_rec.value, m_rec.err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_short_window();
        test_error_pattern();
        test_backpressure();
        test_blanking();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reader for the time-multiplexed 7-segment display bus driven by the team's segment decoders.
- Samples segment lines plus one-hot digit-select lines and waits for each digit's pattern to stay stable.
- Converts each stable pattern back to a 4-bit hex value and hands it out over a valid/ready interface, with an error flag for unrecognised patterns.
- Sits on the display bus as a self-check/loopback monitor.

Parameters:
- NUM_DIGITS, 4, number of digit-select lines (must be ≥2).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (must be ≥2).
- SEG_ACTIVE_LOW, 0, 1 = seg_in and dig_sel are active-low and are inverted at the input register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, bit0=a … bit6=g.
- dig_sel  input  NUM_DIGITS  digit enables, one-hot when valid.
- out_valid  output  1  capture record available.
- out_ready  input  1  consumer accepts the record.
- out_digit  output  $clog2(NUM_DIGITS)  index of the captured digit.
- out_value  output  4  decoded hex value.
- out_err  output  1  pattern not in the hex table.
- drop_pulse  output  1  one-cycle pulse when a capture is discarded because the output is full.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert by design context): every output is 0; state IDLE; cnt=0; sample registers=0.
- Input stage: s_seg/s_sel register seg_in/dig_sel every cycle, after polarity correction. p_seg/p_sel hold the previous s_* values. All comparisons use s_* against p_*.
- same = (s_seg==p_seg) && (s_sel==p_sel). onehot = s_sel has exactly one bit set.
- FSM:
  - IDLE: if onehot, go to TRACK with cnt=0.
  - TRACK:
    - if !onehot, go to IDLE.
    - else if !same, stay in TRACK with cnt=0.
    - else if cnt==STABLE_CYCLES-2, capture and go to HOLD.
    - else cnt++.
  - HOLD: if !onehot, go to IDLE; else if !same, go to TRACK with cnt=0. A stable pattern produces exactly one capture and is never re-emitted while unchanged.
- Capture latency: with inputs constant from cycle k at the input register, out_valid rises at the edge ending cycle k+STABLE_CYCLES+1.
- Capture contents:
  - out_digit = index of the set bit in s_sel.
  - out_value = table lookup of s_seg: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex, gfedcba).
  - Any other pattern: out_value=0, out_err=1.
- Output register, single entry:
  - out_valid stays asserted and out_digit/out_value/out_err stay stable until the cycle out_valid && out_ready.
  - Capture while empty: load the register.
  - Capture in the same cycle as a handshake: load the new record; out_valid stays 1 and no drop occurs.
  - Capture while valid && !ready: keep the old record, assert drop_pulse for 1 cycle, and the FSM still goes to HOLD.
- All-zero dig_sel (blanking) and multi-hot dig_sel count as !onehot and never capture.
- Reset mid-operation clears the pending output record immediately; no partial record survives.
- cnt width: $clog2(STABLE_CYCLES). cnt never exceeds STABLE_CYCLES-2.

Decomposition:
- Package seg7_pkg holds:
  - the 16 pattern constants, SEG_A..SEG_G bit indices, SEG_W=7;
  - the state enum {IDLE, TRACK, HOLD};
  - a capture record struct {digit, value, err}.
- One combinational sub-module, seg7_pattern_decode (7-bit pattern in, 4-bit value plus err out), instantiated once.
- Top module holds the input registers, FSM, counter and output register.

Test Plan:
- Stable 0x5B on dig_sel=0010 for 10 cycles, out_ready=1 -> exactly one record {digit=1,value=2,err=0}, out_valid rising 5 edges after the first sample, and no repeat.
- Pattern 0x6D held 2 cycles, then 0x7D held 8 cycles on digit 0 -> a single record {0,6,0}; the short 0x6D window produces nothing.
- Pattern 0x49 stable on digit 3 -> record {3,0,err=1}.
- out_ready=0, two distinct stable patterns on digits 0 then 2 -> first record {0,…} held, drop_pulse high for one cycle at the second capture; then out_ready=1 -> first record accepted and out_valid falls.
- dig_sel=0110 or 0000 with stable segments for 20 cycles -> no out_valid and FSM in IDLE; then a one-hot dig_sel resumes normal capture.
- rst_n pulled low asynchronously mid-TRACK and while out_valid=1 -> all outputs 0 with no clock edge; after release, a stable 0x06 on digit 2 yields {2,1,0} with normal latency.
